// File: rtl/spi_master_txn.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | spi_master_txn: SPI mode-0 master, address byte plus 0..4 data bytes.    |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module spi_master_txn #(
  parameter int CLK_DIV  = 4,
  parameter int CS_SETUP = 4,
  parameter int BYTE_GAP = 4,
  parameter int CS_HOLD  = 4,
  parameter int CS_IDLE  = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        cmd_wr,
  input  logic [1:0]  cmd_addr,
  input  logic [2:0]  byte_cnt,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        busy,
  output logic        done,
  output logic        SCLK,
  output logic        MOSI,
  input  logic        MISO,
  output logic        SS
);

  localparam int c_M1  = (CLK_DIV > CS_SETUP) ? CLK_DIV : CS_SETUP;
  localparam int c_M2  = (BYTE_GAP > CS_HOLD) ? BYTE_GAP : CS_HOLD;
  localparam int c_M3  = (c_M1 > c_M2) ? c_M1 : c_M2;
  localparam int c_MAX = (c_M3 > CS_IDLE) ? c_M3 : CS_IDLE;
  localparam int c_CW  = (c_MAX > 2) ? $clog2(c_MAX) : 1;

  localparam logic [c_CW-1:0] c_DIV_LAST   = c_CW'(CLK_DIV - 1);
  localparam logic [c_CW-1:0] c_SETUP_LAST = c_CW'(CS_SETUP - 1);
  localparam logic [c_CW-1:0] c_GAP_LAST   = c_CW'(BYTE_GAP - 1);
  localparam logic [c_CW-1:0] c_HOLD_LAST  = c_CW'(CS_HOLD - 1);
  localparam logic [c_CW-1:0] c_IDLE_LAST  = c_CW'(CS_IDLE - 1);

  localparam logic [2:0] c_IDLE  = 3'd0;
  localparam logic [2:0] c_SETUP = 3'd1;
  localparam logic [2:0] c_HIGH  = 3'd2;
  localparam logic [2:0] c_LOW   = 3'd3;
  localparam logic [2:0] c_GAP   = 3'd4;
  localparam logic [2:0] c_HOLD  = 3'd5;
  localparam logic [2:0] c_QUIET = 3'd6;

  logic [2:0]      r_state;
  logic [c_CW-1:0] r_cnt;
  logic [2:0]      r_bit;
  logic [2:0]      r_byte;
  logic [2:0]      r_n;
  logic            r_wr;
  logic [7:0]      r_tx;
  logic [31:0]     r_wbuf;
  logic [7:0]      r_rx;
  logic [31:0]     r_rbuf;

  logic [2:0] w_n;
  logic [7:0] w_rx_next;
  logic [1:0] w_slot;

  assign w_n       = (byte_cnt > 3'd4) ? 3'd4 : byte_cnt;
  assign w_rx_next = {r_rx[6:0], MISO};
  // Data byte k is byte counter value k+1; byte 4 wraps onto slot 3.
  assign w_slot    = r_byte[1:0] - 2'd1;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= c_IDLE;
      r_cnt   <= '0;
      r_bit   <= '0;
      r_byte  <= '0;
      r_n     <= '0;
      r_wr    <= 1'b0;
      r_tx    <= '0;
      r_wbuf  <= '0;
      r_rx    <= '0;
      r_rbuf  <= '0;
      rdata   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      SCLK    <= 1'b0;
      MOSI    <= 1'b0;
      SS      <= 1'b1;
    end else begin
      done  <= 1'b0;
      r_cnt <= r_cnt + c_CW'(1);
      case (r_state)
        c_IDLE: begin
          r_cnt <= '0;
          if (start) begin
            r_state <= c_SETUP;
            busy    <= 1'b1;
            SS      <= 1'b0;
            MOSI    <= cmd_wr;
            r_wr    <= cmd_wr;
            r_n     <= w_n;
            r_tx    <= {cmd_wr, 5'b00000, cmd_addr};
            r_wbuf  <= cmd_wr ? wdata : 32'h0;
            r_bit   <= '0;
            r_byte  <= '0;
            r_rbuf  <= '0;
          end
        end
        c_SETUP: begin
          if (r_cnt == c_SETUP_LAST) begin
            r_state <= c_HIGH;
            SCLK    <= 1'b1;
            r_cnt   <= '0;
          end
        end
        c_HIGH: begin
          // MISO is taken late in the high phase; MOSI advances on the falling edge.
          if (r_cnt == c_DIV_LAST) begin
            r_state <= c_LOW;
            SCLK    <= 1'b0;
            r_cnt   <= '0;
            r_rx    <= w_rx_next;
            r_bit   <= r_bit + 3'd1;
            if (r_bit == 3'd7) begin
              if (r_byte != 3'd0) r_rbuf[{w_slot, 3'b000} +: 8] <= w_rx_next;
              r_byte <= r_byte + 3'd1;
              r_tx   <= r_wbuf[7:0];
              r_wbuf <= {8'h00, r_wbuf[31:8]};
              MOSI   <= (r_byte < r_n) & r_wbuf[7];
            end else begin
              r_tx <= {r_tx[6:0], 1'b0};
              MOSI <= r_tx[6];
            end
          end
        end
        c_LOW: begin
          if (r_cnt == c_DIV_LAST) begin
            r_cnt <= '0;
            if (r_bit != 3'd0) begin
              r_state <= c_HIGH;
              SCLK    <= 1'b1;
            end else if (r_byte <= r_n) begin
              r_state <= c_GAP;
            end else begin
              r_state <= c_HOLD;
            end
          end
        end
        c_GAP: begin
          if (r_cnt == c_GAP_LAST) begin
            r_state <= c_HIGH;
            SCLK    <= 1'b1;
            r_cnt   <= '0;
          end
        end
        c_HOLD: begin
          if (r_cnt == c_HOLD_LAST) begin
            r_state <= c_QUIET;
            SS      <= 1'b1;
            done    <= 1'b1;
            MOSI    <= 1'b0;
            r_cnt   <= '0;
            if (!r_wr && (r_n != 3'd0)) rdata <= r_rbuf;
          end
        end
        c_QUIET: begin
          if (r_cnt == c_IDLE_LAST) begin
            r_state <= c_IDLE;
            busy    <= 1'b0;
            r_cnt   <= '0;
          end
        end
        default: r_state <= c_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_spi_master_txn.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_spi_master_txn: randomized self-checking bench for spi_master_txn.    |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_spi_master_txn;

  localparam int CLK_DIV  = 4;
  localparam int CS_SETUP = 4;
  localparam int BYTE_GAP = 4;
  localparam int CS_HOLD  = 4;
  localparam int CS_IDLE  = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        cmd_wr = 1'b0;
  logic [1:0]  cmd_addr = '0;
  logic [2:0]  byte_cnt = '0;
  logic [31:0] wdata = '0;
  logic [31:0] rdata;
  logic        busy, done, SCLK, MOSI, SS;
  logic        MISO;

  always #5 clk = ~clk;

  spi_master_txn #(
    .CLK_DIV(CLK_DIV), .CS_SETUP(CS_SETUP), .BYTE_GAP(BYTE_GAP),
    .CS_HOLD(CS_HOLD), .CS_IDLE(CS_IDLE)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .cmd_wr(cmd_wr), .cmd_addr(cmd_addr),
    .byte_cnt(byte_cnt), .wdata(wdata), .rdata(rdata), .busy(busy), .done(done),
    .SCLK(SCLK), .MOSI(MOSI), .MISO(MISO), .SS(SS)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Bus observer and slave-side MISO driver.
  int   rises = 0, setup_len = 0, low_run = 0, high_run = 0;
  int   ss_high_run = 0, quiet_len = 0, done_cnt = 0, viol = 0, miso_pos = 0;
  bit   first_rise = 1'b0;
  logic prev_sclk = 1'b0, prev_ss = 1'b1;
  logic        mosi_q[$];
  int          low_runs[$];
  int          high_runs[$];
  logic [7:0]  miso_bytes[$];
  logic [7:0]  regs[4];
  logic [31:0] model_rdata = '0;

  function automatic logic miso_bit(input int pos);
    logic [7:0] b;
    if (pos / 8 >= miso_bytes.size()) return 1'b0;
    b = miso_bytes[pos / 8];
    return b[7 - pos % 8];
  endfunction

  initial begin : monitor
    MISO = 1'b0;
    forever begin
      @(negedge clk);
      if (SS && SCLK) viol++;
      if (done) done_cnt++;
      if (prev_ss && !SS) begin
        quiet_len  = ss_high_run;
        low_run    = 1;
        first_rise = 1'b1;
        miso_pos   = 0;
        MISO       = miso_bit(0);
      end else if (!SS) begin
        if (SCLK && !prev_sclk) begin
          rises++;
          mosi_q.push_back(MOSI);
          if (first_rise) setup_len = low_run;
          else low_runs.push_back(low_run);
          first_rise = 1'b0;
          high_run   = 1;
        end else if (SCLK) begin
          high_run++;
        end else if (prev_sclk) begin
          high_runs.push_back(high_run);
          low_run = 1;
          miso_pos++;
          MISO = miso_bit(miso_pos);
        end else begin
          low_run++;
        end
      end else if (!prev_ss) begin
        low_runs.push_back(low_run);
        ss_high_run = 1;
      end else begin
        ss_high_run++;
      end
      prev_ss   = SS;
      prev_sclk = SCLK;
    end
  end

  task automatic clear_mon();
    rises = 0; done_cnt = 0; viol = 0; setup_len = -1;
    mosi_q.delete(); low_runs.delete(); high_runs.delete();
  endtask

  task automatic set_miso(input int n, input logic [39:0] vec, input bit use_vec);
    miso_bytes.delete();
    for (int j = 0; j <= n; j++)
      miso_bytes.push_back(use_vec ? vec[8*j +: 8] : 8'($urandom_range(0, 255)));
  endtask

  task automatic launch(input logic wr, input logic [1:0] addr, input logic [2:0] bc,
                        input logic [31:0] wd, input bit hold);
    cmd_wr = wr; cmd_addr = addr; byte_cnt = bc; wdata = wd; start = 1'b1;
    @(negedge clk);
    check("busy_on", busy, 1);
    if (!hold) start = 1'b0;
  endtask

  // Reference: expected byte stream, edge count, phase lengths and rdata per transaction.
  task automatic expect_txn(input logic wr, input logic [1:0] addr, input logic [2:0] bc,
                            input logic [31:0] wd, input bit release_start);
    int n, k, bad, idx;
    logic [7:0]  eb[5];
    logic [7:0]  got[5];
    logic [31:0] exp_rd;
    n = (bc > 3'd4) ? 4 : int'(bc);
    eb[0] = {wr, 5'b00000, addr};
    exp_rd = model_rdata;
    if (!wr && n > 0) exp_rd = '0;
    for (int j = 0; j < n; j++) begin
      eb[j+1] = wr ? wd[8*j +: 8] : 8'h00;
      if (!wr) exp_rd[8*j +: 8] = miso_bytes[j+1];
    end
    k = 0;
    while (!done && k < 3000) begin @(negedge clk); k++; end
    check("done_seen", done, 1);
    if (release_start) start = 1'b0;
    check("rdata", rdata, exp_rd);
    model_rdata = exp_rd;
    k = 0;
    while (busy && k < 100) begin @(negedge clk); k++; end
    check("busy_drop", busy, 0);
    check("done_pulses", done_cnt, 1);
    check("rises", rises, 8 * (n + 1));
    for (int j = 0; j <= n; j++) begin
      got[j] = 8'h00;
      for (int b = 0; b < 8; b++) begin
        idx = 8 * j + b;
        if (idx < mosi_q.size()) got[j] = {got[j][6:0], mosi_q[idx]};
      end
      check($sformatf("mosi_byte%0d", j), got[j], eb[j]);
    end
    check("setup_len", setup_len, CS_SETUP);
    bad = 0;
    foreach (high_runs[i]) if (high_runs[i] != CLK_DIV) bad++;
    foreach (low_runs[i]) begin
      if (i == low_runs.size() - 1) begin
        if (low_runs[i] != CLK_DIV + CS_HOLD) bad++;
      end else if (i % 8 == 7) begin
        if (low_runs[i] != CLK_DIV + BYTE_GAP) bad++;
      end else if (low_runs[i] != CLK_DIV) bad++;
    end
    check("phase_timing", bad, 0);
    check("low_run_count", low_runs.size(), rises);
    if (low_runs.size() > 0) check("hold_len", low_runs[low_runs.size()-1], CLK_DIV + CS_HOLD);
    if (n > 0 && low_runs.size() > 8) check("gap_len", low_runs[7], CLK_DIV + BYTE_GAP);
    check("sclk_while_ss_high", viol, 0);
    if (wr && n > 0) regs[addr] = got[1];
  endtask

  task automatic run_txn(input logic wr, input logic [1:0] addr, input logic [2:0] bc,
                         input logic [31:0] wd, input bit use_vec, input logic [39:0] vec);
    int n;
    n = (bc > 3'd4) ? 4 : int'(bc);
    clear_mon();
    set_miso(n, vec, use_vec);
    launch(wr, addr, bc, wd, 1'b0);
    expect_txn(wr, addr, bc, wd, 1'b0);
  endtask

  initial begin : stimulus
    for (int i = 0; i < 4; i++) regs[i] = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_ss", SS, 1);
    check("rst_sclk", SCLK, 0);
    check("rst_mosi", MOSI, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_rdata", rdata, 0);
    reset = 1'b1;
    @(negedge clk);

    // Abort a write mid-bit with reset.
    clear_mon();
    set_miso(4, 40'h0, 1'b0);
    launch(1'b1, 2'd1, 3'd4, 32'hDEADBEEF, 1'b0);
    repeat (30) @(negedge clk);
    check("abort_pre_ss", SS, 0);
    reset = 1'b0;
    @(negedge clk);
    check("abort_ss", SS, 1);
    check("abort_sclk", SCLK, 0);
    check("abort_busy", busy, 0);
    reset = 1'b1;
    done_cnt = 0;
    repeat (20) @(negedge clk);
    check("abort_no_done", done_cnt, 0);
    check("abort_rdata", rdata, 0);

    // Write then read back through the slave register model.
    run_txn(1'b1, 2'd2, 3'd1, 32'h0000005A, 1'b0, 40'h0);
    check("reg2", regs[2], 8'h5A);
    run_txn(1'b0, 2'd2, 3'd1, 32'h0, 1'b1, {24'h0, regs[2], 8'h00});
    check("reg2_readback", rdata, 32'h0000005A);

    run_txn(1'b0, 2'd1, 3'd2, 32'hFFFFFFFF, 1'b1, 40'h00_003C_C300);
    check("read2_rdata", rdata, 32'h00003CC3);

    run_txn(1'b1, 2'd0, 3'd7, 32'h44332211, 1'b0, 40'h0);
    check("clamp_keeps_rdata", rdata, 32'h00003CC3);

    run_txn(1'b0, 2'd3, 3'd0, 32'h0, 1'b0, 40'h0);
    check("zero_len_rdata", rdata, 32'h00003CC3);

    // start held high across a full transaction and its quiet time.
    clear_mon();
    set_miso(2, 40'h0, 1'b0);
    launch(1'b1, 2'd3, 3'd2, 32'h0000A55A, 1'b1);
    expect_txn(1'b1, 2'd3, 3'd2, 32'h0000A55A, 1'b0);
    clear_mon();
    set_miso(2, 40'h0, 1'b0);
    expect_txn(1'b1, 2'd3, 3'd2, 32'h0000A55A, 1'b1);
    check("quiet_min", quiet_len >= CS_IDLE, 1);

    for (int t = 0; t < 6; t++) begin
      run_txn(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)),
              $urandom, 1'b0, 40'h0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
